// File: rtl/count_capture_fifo.sv
// Timestamps asynchronous event edges by snapshotting the counter bus into a
// first-word-fall-through FIFO drained through a valid/ready reader port.
module count_capture_fifo #(
    parameter int CNT_W       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           count_in,
    input  logic                       evt_in,
    input  logic                       cap_en,
    output logic [CNT_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   cap_pulse;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       mem [DEPTH];

    // Synchronizer chain plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cap_pulse = sync_q[SYNC_STAGES-1] & ~s_d & cap_en;
    assign empty     = (level == '0);
    assign full      = (level == LVL_FULL);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a capture when the reader frees a slot in the same cycle
    assign push_ok   = cap_pulse & (~full | pop);
    assign drop      = cap_pulse & full & ~pop;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= count_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Scoreboard bench for count_capture_fifo: directed events push expected
// timestamps, a negedge monitor checks every accepted pop against them.
module tb_count_capture_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       evt_in;
    logic       cap_en;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    count_capture_fifo #(.CNT_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .evt_in    (evt_in),
        .cap_en    (cap_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a pop happens at the next posedge whenever valid & ready hold at negedge
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got %h, scoreboard empty", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got %h, expected %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic capture(input logic [3:0] val, input bit expect_it);
        if (expect_it) exp_q.push_back(val);
        count_in = val;
        evt_in   = 1'b1;
        repeat (3) tick();
        evt_in   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!empty && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check_output("drain_empty", int'(empty), 1);
        check_output("drain_scoreboard", exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b0;
        count_in  = 4'h0;
        evt_in    = 1'b0;
        cap_en    = 1'b1;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();
        check_output("reset_valid", int'(out_valid), 0);
        check_output("reset_empty", int'(empty), 1);
        check_output("reset_full", int'(full), 0);
        check_output("reset_ovf", int'(overflow), 0);
        rst = 1'b1;
        tick();

        // Test 1: reset with entries stored flushes them
        capture(4'h3, 1'b0);
        capture(4'h4, 1'b0);
        capture(4'h5, 1'b0);
        check_output("t1_level_pre", int'(level), 3);
        rst = 1'b0;
        #1;
        check_output("t1_valid", int'(out_valid), 0);
        check_output("t1_level", int'(level), 0);
        check_output("t1_empty", int'(empty), 1);
        check_output("t1_ovf", int'(overflow), 0);
        check_output("t1_data", int'(out_data), 0);
        tick();
        rst = 1'b1;
        tick();
        capture(4'hC, 1'b1);
        check_output("t1_level_post", int'(level), 1);
        drain();

        // Test 2: long event high gives exactly one capture, two-cycle latency
        exp_q.push_back(4'h5);
        count_in = 4'h5;
        evt_in   = 1'b1;
        repeat (2) tick();
        check_output("t2_level_early", int'(level), 0);
        tick();
        check_output("t2_level_edge12", int'(level), 1);
        repeat (17) tick();
        check_output("t2_level_held", int'(level), 1);
        check_output("t2_data", int'(out_data), 5);
        evt_in = 1'b0;
        repeat (4) tick();
        check_output("t2_level_end", int'(level), 1);
        drain();

        // Test 3: fifth event on a full FIFO is dropped and flagged
        capture(4'h1, 1'b1);
        capture(4'h2, 1'b1);
        capture(4'h3, 1'b1);
        capture(4'h4, 1'b1);
        check_output("t3_full", int'(full), 1);
        check_output("t3_ovf_before", int'(overflow), 0);
        capture(4'h5, 1'b0);
        check_output("t3_ovf", int'(overflow), 1);
        check_output("t3_level", int'(level), 4);
        drain();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("t3_ovf_cleared", int'(overflow), 0);

        // Test 4: push and pop together while full
        capture(4'h6, 1'b1);
        capture(4'h7, 1'b1);
        capture(4'h8, 1'b1);
        capture(4'h9, 1'b1);
        exp_q.push_back(4'hA);
        count_in = 4'hA;
        evt_in   = 1'b1;
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("t4_level", int'(level), 4);
        check_output("t4_full", int'(full), 1);
        check_output("t4_ovf", int'(overflow), 0);
        evt_in = 1'b0;
        repeat (4) tick();
        drain();

        // Test 5: wrapping counter values come back in order
        capture(4'hE, 1'b1);
        capture(4'hF, 1'b1);
        capture(4'h0, 1'b1);
        capture(4'h1, 1'b1);
        drain();

        // Test 6: disabled capture, then clear colliding with a new drop
        capture(4'h2, 1'b1);
        capture(4'h3, 1'b1);
        capture(4'h4, 1'b1);
        capture(4'h5, 1'b1);
        cap_en = 1'b0;
        capture(4'h6, 1'b0);
        cap_en = 1'b1;
        check_output("t6_level_disabled", int'(level), 4);
        check_output("t6_ovf_disabled", int'(overflow), 0);
        count_in = 4'h8;
        evt_in   = 1'b1;
        repeat (2) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("t6_ovf_set_wins", int'(overflow), 1);
        check_output("t6_level", int'(level), 4);
        evt_in = 1'b0;
        repeat (4) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("t6_ovf_clear", int'(overflow), 0);
        drain();

        check_output("final_scoreboard", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
